// File: rtl/counter_ctrl.sv
// ---------------------------------------------------------------------------
// counter_ctrl
//
// Purpose:
//   Arbitrates two requesters for a shared 3-bit up/down counter and walks the
//   counter to the granted requester's target value one step at a time. After
//   each UP/DOWN pulse the controller waits SETTLE cycles before re-sampling
//   the fed-back count, then repeats until the count matches the target.
//
// Parameters:
//   SETTLE  (1..15, default 2)  cycles spent in WAIT after every step pulse
//
// Ports:
//   i_clk          sole clock, rising-edge
//   i_mr           synchronous active-high reset
//   i_req0/1       move requests from requester 0 / 1
//   i_tgt0/1[2:0]  target count per requester, captured at grant
//   i_co[2:0]      current count fed back from the counter
//   o_up/o_down    one-cycle step commands to the counter
//   o_gnt[1:0]     one-hot owner (bit0 = requester 0, bit1 = requester 1)
//   o_ack0/1       one-cycle completion pulses
//   o_busy         high whenever the controller is not idle
//   o_err          one-cycle timeout flag (only meaningful with the macro)
//
// Configuration:
//   COUNTER_CTRL_TIMEOUT_EN  when defined, a step counter aborts an operation
//                            that has not matched after 8 steps and pulses
//                            o_err together with the ack. When undefined,
//                            o_err is tied low and operations run until match.
// ---------------------------------------------------------------------------
module counter_ctrl #(
  parameter int SETTLE = 2
) (
  input  logic       i_clk,
  input  logic       i_mr,
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic [2:0] i_tgt0,
  input  logic [2:0] i_tgt1,
  input  logic [2:0] i_co,
  output logic       o_up,
  output logic       o_down,
  output logic [1:0] o_gnt,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_busy,
  output logic       o_err
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    STEP,
    WAIT,
    DONE
  } state_t;

  localparam logic [3:0] W_SETTLE_M1 = 4'(SETTLE - 1);

  state_t     r_state;
  logic [2:0] r_target;
  logic [3:0] r_waitCnt;
  logic       r_prio;
  logic       r_up;
  logic       r_down;
  logic [1:0] r_gnt;
  logic       r_ack0;
  logic       r_ack1;
  logic       r_busy;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  logic [3:0] r_stepCnt;
  logic       r_errPend;
  logic       r_err;
`endif

  logic w_anyReq;
  logic w_pick1;

  // Requester 1 wins when it is the only one asking, or when both ask and
  // the round-robin pointer favours it (r_prio = 1 means requester 1 next).
  assign w_anyReq = i_req0 | i_req1;
  assign w_pick1  = i_req1 & (~i_req0 | r_prio);

  // Single controller process. Pulse outputs (step commands, acks, error)
  // default low every cycle so they only stay high for the one cycle in
  // which a state explicitly raises them. The timeout reason is remembered
  // in r_errPend so the error can be emitted in the same cycle as the ack.
  always_ff @(posedge i_clk) begin
    if (i_mr) begin
      r_state   <= IDLE;
      r_target  <= 3'd0;
      r_waitCnt <= 4'd0;
      r_prio    <= 1'b0;
      r_up      <= 1'b0;
      r_down    <= 1'b0;
      r_gnt     <= 2'b00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
      r_stepCnt <= 4'd0;
      r_errPend <= 1'b0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_up   <= 1'b0;
      r_down <= 1'b0;
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state  <= CHECK;
            r_busy   <= 1'b1;
            r_gnt    <= w_pick1 ? 2'b10 : 2'b01;
            r_target <= w_pick1 ? i_tgt1 : i_tgt0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
            r_stepCnt <= 4'd0;
            r_errPend <= 1'b0;
`endif
          end
        end

        CHECK: begin
          if (i_co == r_target) begin
            r_state <= DONE;
          end
`ifdef COUNTER_CTRL_TIMEOUT_EN
          else if (r_stepCnt >= 4'd8) begin
            r_state   <= DONE;
            r_errPend <= 1'b1;
          end
`endif
          else begin
            r_state <= STEP;
            if (i_co < r_target) begin
              r_up <= 1'b1;
            end else begin
              r_down <= 1'b1;
            end
          end
        end

        // The step command was raised on entry and drops by default here.
        STEP: begin
          r_state   <= WAIT;
          r_waitCnt <= W_SETTLE_M1;
`ifdef COUNTER_CTRL_TIMEOUT_EN
          r_stepCnt <= r_stepCnt + 4'd1;
`endif
        end

        WAIT: begin
          if (r_waitCnt == 4'd0) begin
            r_state <= CHECK;
          end else begin
            r_waitCnt <= r_waitCnt - 4'd1;
          end
        end

        // The requester just served loses priority on the next tie.
        DONE: begin
          r_state <= IDLE;
          r_ack0  <= r_gnt[0];
          r_ack1  <= r_gnt[1];
          r_prio  <= r_gnt[0];
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
`ifdef COUNTER_CTRL_TIMEOUT_EN
          r_err   <= r_errPend;
`endif
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_up   = r_up;
  assign o_down = r_down;
  assign o_gnt  = r_gnt;
  assign o_ack0 = r_ack0;
  assign o_ack1 = r_ack1;
  assign o_busy = r_busy;

`ifdef COUNTER_CTRL_TIMEOUT_EN
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter_ctrl
//
// Purpose:
//   Self-checking bench for counter_ctrl. Models the external saturating
//   up/down counter, drives directed and randomized request sequences, and
//   predicts each transaction (winner, step count and direction, pulse
//   spacing, ack latency, final count) from the arbitration and stepping
//   rules using plain arithmetic.
// ---------------------------------------------------------------------------
module tb_counter_ctrl;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       mr;
  logic       req0;
  logic       req1;
  logic [2:0] tgt0;
  logic [2:0] tgt1;
  logic [2:0] co;
  logic       up;
  logic       down;
  logic [1:0] gnt;
  logic       ack0;
  logic       ack1;
  logic       busy;
  logic       err;
  logic       freezeCo;

  int numChecks = 0;
  int numErrors = 0;
  int expPrio   = 0;
  int expCo     = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.SETTLE(SETTLE)) dut (
    .i_clk  (clk),
    .i_mr   (mr),
    .i_req0 (req0),
    .i_req1 (req1),
    .i_tgt0 (tgt0),
    .i_tgt1 (tgt1),
    .i_co   (co),
    .o_up   (up),
    .o_down (down),
    .o_gnt  (gnt),
    .o_ack0 (ack0),
    .o_ack1 (ack1),
    .o_busy (busy),
    .o_err  (err)
  );

  // Saturating up/down counter sharing the controller's reset. freezeCo
  // pins it in place so the timeout path can be exercised.
  always @(posedge clk) begin
    if (mr) begin
      co <= 3'd0;
    end else if (!freezeCo) begin
      if (up && co != 3'd7) begin
        co <= co + 3'd1;
      end else if (down && co != 3'd0) begin
        co <= co - 3'd1;
      end
    end
  end

  // Hard stop in case something upstream of the bounded loops misbehaves.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed !== expected) begin
      numErrors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Round-robin reference: on a tie the requester not served last wins.
  function automatic int pickWinner(input logic r0, input logic r1);
    if (r0 && r1) return expPrio;
    return r1 ? 1 : 0;
  endfunction

  task automatic applyReset();
    mr   = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rstBusy", int'(busy), 0);
    checkOutput("rstGnt",  int'(gnt), 0);
    checkOutput("rstUp",   int'(up), 0);
    checkOutput("rstDown", int'(down), 0);
    checkOutput("rstAck",  int'(ack0 | ack1), 0);
    checkOutput("rstErr",  int'(err), 0);
    checkOutput("rstCo",   int'(co), 0);
    mr      = 1'b0;
    expPrio = 0;
    expCo   = 0;
  endtask

  // Follows one granted operation from its grant edge to its ack. The
  // request for 'who' must already be driven so the next edge grants it.
  task automatic applyStimulus(input int who, input int tgt, input bit timeoutCase,
                               input bit perturb);
    int  steps;
    int  expLat;
    int  ups;
    int  downs;
    int  lastPulse;
    bit  upDir;
    bit  acked;
    int  expGnt;
    steps     = timeoutCase ? 8 : ((tgt > expCo) ? tgt - expCo : expCo - tgt);
    upDir     = (tgt > expCo);
    expLat    = 2 + steps * (2 + SETTLE);
    expGnt    = (who == 0) ? 1 : 2;
    ups       = 0;
    downs     = 0;
    lastPulse = -1;
    acked     = 1'b0;

    @(negedge clk);
    checkOutput("grant", int'(gnt), expGnt);
    checkOutput("busyAtGrant", int'(busy), 1);
    if (perturb) begin
      if ($urandom_range(0, 1) == 1) begin
        if (who == 0) req0 = 1'b0; else req1 = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        if (who == 0) tgt0 = 3'($urandom_range(0, 7));
        else          tgt1 = 3'($urandom_range(0, 7));
      end
    end

    for (int idx = 0; idx <= 400 && !acked; idx++) begin
      if (idx > 0) @(negedge clk);
      checkOutput("upDownExcl", int'(up & down), 0);
      if (up | down) begin
        if (up) ups++;
        if (down) downs++;
        if (lastPulse >= 0) checkOutput("pulseGap", idx - lastPulse, 2 + SETTLE);
        lastPulse = idx;
      end
      if (ack0 | ack1) begin
        acked = 1'b1;
        checkOutput("ackLatency", idx, expLat);
        checkOutput("ack0", int'(ack0), (who == 0) ? 1 : 0);
        checkOutput("ack1", int'(ack1), (who == 1) ? 1 : 0);
        checkOutput("errAtAck", int'(err), timeoutCase ? 1 : 0);
        checkOutput("busyAtAck", int'(busy), 0);
        checkOutput("gntAtAck", int'(gnt), 0);
      end else if (idx > 0) begin
        checkOutput("gntHeld", int'(gnt), expGnt);
        checkOutput("busyHeld", int'(busy), 1);
      end
    end
    if (!acked) checkOutput("ackTimeout", 0, 1);

    checkOutput("upCount", ups, upDir ? steps : 0);
    checkOutput("downCount", downs, upDir ? 0 : steps);
    checkOutput("finalCo", int'(co), timeoutCase ? expCo : tgt);

    expPrio = (who == 0) ? 1 : 0;
    if (!timeoutCase) expCo = tgt;
  endtask

  initial begin
    int  w;
    int  o;
    int  mask;
    int  ups;
    bit  seen;
    bit  ackSeen;
    bit  errSeen;

    freezeCo = 1'b0;
    mr       = 1'b1;
    req0     = 1'b0;
    req1     = 1'b0;
    tgt0     = 3'd0;
    tgt1     = 3'd0;

    applyReset();

    // Walk up to 3, then requester 1 walks back down to 0.
    tgt0 = 3'd3; req0 = 1'b1;
    applyStimulus(0, 3, 1'b0, 1'b0);
    req0 = 1'b0;
    tgt1 = 3'd0; req1 = 1'b1;
    applyStimulus(1, 0, 1'b0, 1'b0);
    req1 = 1'b0;

    // Reach 5, then hold REQ0 so it is re-arbitrated with an equal target.
    tgt0 = 3'd5; req0 = 1'b1;
    applyStimulus(0, 5, 1'b0, 1'b0);
    applyStimulus(0, 5, 1'b0, 1'b0);
    req0 = 1'b0;

    // Simultaneous pair after reset; requester 0 keeps asking afterwards.
    applyReset();
    tgt0 = 3'd1; tgt1 = 3'd2; req0 = 1'b1; req1 = 1'b1;
    w = pickWinner(req0, req1);
    applyStimulus(w, (w == 1) ? int'(tgt1) : int'(tgt0), 1'b0, 1'b0);
    w = pickWinner(req0, req1);
    applyStimulus(w, (w == 1) ? int'(tgt1) : int'(tgt0), 1'b0, 1'b0);
    if (w == 1) req1 = 1'b0; else req0 = 1'b0;
    w = pickWinner(req0, req1);
    applyStimulus(w, (w == 1) ? int'(tgt1) : int'(tgt0), 1'b0, 1'b0);
    req0 = 1'b0; req1 = 1'b0;

    // Reset asserted while the controller sits in WAIT.
    applyReset();
    tgt0 = 3'd7; req0 = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (up) seen = 1'b1;
    end
    checkOutput("sawUpBeforeReset", int'(seen), 1);
    @(negedge clk);
    mr = 1'b1; req0 = 1'b0;
    @(negedge clk);
    checkOutput("midRstBusy", int'(busy), 0);
    checkOutput("midRstGnt", int'(gnt), 0);
    checkOutput("midRstStep", int'(up | down), 0);
    checkOutput("midRstCo", int'(co), 0);
    mr = 1'b0; expPrio = 0; expCo = 0;
    tgt1 = 3'($urandom_range(1, 7)); req1 = 1'b1;
    applyStimulus(1, int'(tgt1), 1'b0, 1'b0);
    req1 = 1'b0;

    // Counter pinned at 0 with an unreachable target.
    applyReset();
    freezeCo = 1'b1;
    tgt0 = 3'd7; req0 = 1'b1;
`ifdef COUNTER_CTRL_TIMEOUT_EN
    applyStimulus(0, 7, 1'b1, 1'b0);
    req0 = 1'b0;
`else
    @(negedge clk);
    checkOutput("stuckGrant", int'(gnt), 1);
    ups = 0; ackSeen = 1'b0; errSeen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (up) ups++;
      if (ack0 | ack1) ackSeen = 1'b1;
      if (err) errSeen = 1'b1;
    end
    checkOutput("stuckUpsContinue", int'(ups > 8), 1);
    checkOutput("stuckNoAck", int'(ackSeen), 0);
    checkOutput("stuckNoErr", int'(errSeen), 0);
    req0 = 1'b0;
`endif
    freezeCo = 1'b0;
    applyReset();

    // Randomized request mixes, with mid-operation REQ drops and TGT changes.
    for (int n = 0; n < 25; n++) begin
      mask = int'($urandom_range(1, 3));
      tgt0 = 3'($urandom_range(0, 7));
      tgt1 = 3'($urandom_range(0, 7));
      req0 = mask[0];
      req1 = mask[1];
      w = pickWinner(req0, req1);
      applyStimulus(w, (w == 1) ? int'(tgt1) : int'(tgt0), 1'b0, 1'b1);
      if (w == 1) req1 = 1'b0; else req0 = 1'b0;
      if (mask == 3) begin
        o = 1 - w;
        applyStimulus(o, (o == 1) ? int'(tgt1) : int'(tgt0), 1'b0, 1'b1);
        if (o == 1) req1 = 1'b0; else req0 = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

endmodule
